// File: rtl/mul_rr_scheduler.sv
// Round-robin front end for one shared pipelined 9x9 signed multiplier.
// Grants at most one requester per cycle, registers its operands into the
// multiplier, and carries {valid, id, ovf} down a tag pipe so each product
// comes back to the right requester. A RUN/DRAIN/IDLE state machine lets
// the shared datapath be quiesced without losing operations already issued.
module mul_rr_scheduler #(
  parameter int N       = 4,
  parameter int MUL_LAT = 10,
  parameter int IDW     = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N-1:0]                   req_valid,
  output logic [N-1:0]                   req_ready,
  input  logic [N*9-1:0]                 req_a,
  input  logic [N*9-1:0]                 req_b,
  input  logic                           stop,
  output logic [8:0]                     mul_a,
  output logic [8:0]                     mul_b,
  output logic                           mul_en,
  input  logic [16:0]                    mul_p,
  output logic                           rsp_valid,
  output logic [IDW-1:0]                 rsp_id,
  output logic [16:0]                    rsp_p,
  output logic                           rsp_ovf,
  output logic [$clog2(MUL_LAT+2)-1:0]   inflight,
  output logic                           busy
);

  localparam int CW = $clog2(MUL_LAT+2);
  localparam logic [IDW:0] NW = (IDW+1)'(N);
  // The only 9x9 signed product that does not fit in 17 bits is (-256)*(-256).
  localparam logic [8:0] MOST_NEG = 9'h100;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_IDLE} state_t;

  state_t           r_state;
  logic             r_en;
  logic [IDW-1:0]   r_ptr;
  logic [8:0]       r_mul_a;
  logic [8:0]       r_mul_b;
  logic             r_tag_vld [MUL_LAT+1];
  logic [IDW-1:0]   r_tag_id  [MUL_LAT+1];
  logic             r_tag_ovf [MUL_LAT+1];
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic [16:0]      r_rsp_p;
  logic             r_rsp_ovf;
  logic [CW-1:0]    r_inflight;
  logic             r_busy;

  logic [8:0]       w_a [N];
  logic [8:0]       w_b [N];
  logic             w_allow;
  logic             w_found;
  logic [IDW-1:0]   w_gid;
  logic [N-1:0]     w_grant;
  logic [IDW:0]     w_sum;
  logic [IDW:0]     w_ptr_sum;
  logic [IDW-1:0]   w_ptr_next;
  logic             w_ovf;
  logic             w_rsp_edge;
  logic [CW-1:0]    w_inflight_next;

  // Unpack the flat operand buses into per-requester lanes.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign w_a[gi] = req_a[9*gi +: 9];
      assign w_b[gi] = req_b[9*gi +: 9];
    end
  endgenerate

  // Grants only once out of reset, in RUN, and never in a cycle where stop is high.
  assign w_allow = r_en && (r_state == S_RUN) && !stop;

  // Round-robin search starting at r_ptr, wrapping modulo N; first valid requester wins.
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_sum   = '0;
    w_grant = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= NW) w_sum = w_sum - NW;
      if (w_allow && !w_found && req_valid[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gid   = w_sum[IDW-1:0];
      end
    end
    w_grant[w_gid] = w_found;
  end

  // Pointer moves just past the winner, wrapping N-1 back to 0.
  always_comb begin
    w_ptr_sum  = {1'b0, w_gid} + (IDW+1)'(1);
    w_ptr_next = (w_ptr_sum >= NW) ? '0 : w_ptr_sum[IDW-1:0];
  end

  assign w_ovf      = (w_a[w_gid] == MOST_NEG) && (w_b[w_gid] == MOST_NEG);
  assign w_rsp_edge = r_tag_vld[MUL_LAT];

  // Accept and response on the same edge cancel out.
  always_comb begin
    w_inflight_next = r_inflight;
    if (w_found && !w_rsp_edge)      w_inflight_next = r_inflight + CW'(1);
    else if (!w_found && w_rsp_edge) w_inflight_next = r_inflight - CW'(1);
  end

  // Control state machine: stop quiesces issue, drains, then parks in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (stop) r_state <= S_DRAIN;
        S_DRAIN: begin
          if (!stop)                 r_state <= S_RUN;
          else if (r_inflight == '0) r_state <= S_IDLE;
        end
        S_IDLE:  if (!stop) r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  // Multiplier enable and arbitration pointer; operands are zero on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_ptr   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      r_en <= 1'b1;
      if (w_found) begin
        r_ptr   <= w_ptr_next;
        r_mul_a <= w_a[w_gid];
        r_mul_b <= w_b[w_gid];
      end else begin
        r_mul_a <= '0;
        r_mul_b <= '0;
      end
    end
  end

  // Tag pipe head: captures the winner on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld[0] <= 1'b0;
      r_tag_id[0]  <= '0;
      r_tag_ovf[0] <= 1'b0;
    end else begin
      r_tag_vld[0] <= w_found;
      r_tag_id[0]  <= w_gid;
      r_tag_ovf[0] <= w_ovf;
    end
  end

  // Remaining tag stages track the multiplier pipeline one edge at a time.
  generate
    for (genvar gi = 1; gi <= MUL_LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag_vld[gi] <= 1'b0;
          r_tag_id[gi]  <= '0;
          r_tag_ovf[gi] <= 1'b0;
        end else begin
          r_tag_vld[gi] <= r_tag_vld[gi-1];
          r_tag_id[gi]  <= r_tag_id[gi-1];
          r_tag_ovf[gi] <= r_tag_ovf[gi-1];
        end
      end
    end
  endgenerate

  // Response register: one-cycle strobe, payload held between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_p     <= '0;
      r_rsp_ovf   <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_edge;
      if (w_rsp_edge) begin
        r_rsp_id  <= r_tag_id[MUL_LAT];
        r_rsp_p   <= mul_p;
        r_rsp_ovf <= r_tag_ovf[MUL_LAT];
      end
    end
  end

  // Outstanding-operation counter and its nonzero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_inflight <= w_inflight_next;
      r_busy     <= (w_inflight_next != '0);
    end
  end

  assign req_ready = w_grant;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign mul_en    = r_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_p     = r_rsp_p;
  assign rsp_ovf   = r_rsp_ovf;
  assign inflight  = r_inflight;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Scoreboard bench for mul_rr_scheduler with a behavioural pipelined multiplier.
module tb_mul_rr_scheduler;

  localparam int N       = 4;
  localparam int MUL_LAT = 10;
  localparam int IDW     = 2;
  localparam int CW      = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*9-1:0]    req_a;
  logic [N*9-1:0]    req_b;
  logic              stop;
  logic [8:0]        mul_a;
  logic [8:0]        mul_b;
  logic              mul_en;
  logic [16:0]       mul_p;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [16:0]       rsp_p;
  logic              rsp_ovf;
  logic [CW-1:0]     inflight;
  logic              busy;

  mul_rr_scheduler #(.N(N), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .stop(stop), .mul_a(mul_a), .mul_b(mul_b),
    .mul_en(mul_en), .mul_p(mul_p), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_p(rsp_p), .rsp_ovf(rsp_ovf), .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: P valid MUL_LAT edges after operands appear.
  logic signed [17:0] prod_full;
  logic [16:0]        mp [MUL_LAT];
  assign prod_full = $signed(mul_a) * $signed(mul_b);
  assign mul_p     = mp[MUL_LAT-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MUL_LAT; i++) mp[i] <= '0;
    end else if (mul_en) begin
      mp[0] <= prod_full[16:0];
      for (int i = 1; i < MUL_LAT; i++) mp[i] <= mp[i-1];
    end
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [16:0]    p;
    logic           ovf;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: retire responses, check counters, record new accepts.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          $display("rsp cyc=%0d id=%0d p=%0h ovf=%0d", cyc, rsp_id, rsp_p, rsp_ovf);
          check_eq("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          check_eq("rsp_p", 32'(rsp_p), 32'(mon_e.p));
          check_eq("rsp_ovf", 32'(rsp_ovf), 32'(mon_e.ovf));
          check_eq("rsp_latency", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      check_eq("inflight", 32'(inflight), 32'(sb.size()));
      check_eq("busy", 32'(busy), 32'(sb.size() != 0));
      check_eq("ready_masked", 32'(req_ready & ~req_valid), 32'd0);
      check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          int sa, sbv, pa;
          sa  = int'($signed(req_a[9*i +: 9]));
          sbv = int'($signed(req_b[9*i +: 9]));
          pa  = sa * sbv;
          mon_e.id  = IDW'(i);
          mon_e.p   = pa[16:0];
          mon_e.ovf = (pa == 65536);
          mon_e.cyc = cyc + MUL_LAT + 2;
          sb.push_back(mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[9*i +: 9] = 9'(a);
    req_b[9*i +: 9] = 9'(b);
  endtask

  task automatic chk_ready(input string tag, input logic [N-1:0] exp);
    @(negedge clk);
    check_eq(tag, 32'(req_ready), 32'(exp));
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    tick();
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ca[4];
    int cb[4];
    ca = '{-256, -256, 255, 0};
    cb = '{-256, 255, 255, -1};

    rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_mul_en", 32'(mul_en), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_p", 32'(rsp_p), 32'd0);
    check_eq("rst_inflight", 32'(inflight), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1; req_valid = '0;
    tick();
    check_eq("mul_en_on", 32'(mul_en), 32'd1);

    // Single operation on requester 2
    set_op(2, 7, -3);
    req_valid = 4'b0100;
    chk_ready("t1_ready", 4'b0100);
    tick();
    check_eq("t1_mul_a", 32'(mul_a), 32'h007);
    check_eq("t1_mul_b", 32'(mul_b), 32'h1FD);
    req_valid = '0;
    tick();
    check_eq("t1_mul_a_idle", 32'(mul_a), 32'h000);
    wait_empty("t1_done");
    check_eq("t1_rsp_p", 32'(rsp_p), 32'h1FFEB);
    check_eq("t1_rsp_id", 32'(rsp_id), 32'd2);

    // Wrap and skip: pointer now 3
    set_op(1, 3, 4);
    req_valid = 4'b0010;
    chk_ready("t3_wrap", 4'b0010);
    tick();
    set_op(3, -5, 6);
    req_valid = 4'b1000;
    chk_ready("t3_skip", 4'b1000);
    tick();
    req_valid = '0;

    // Fairness: all requesting for 8 cycles, pointer now 0
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_op(i, k*13 - 50 + i, 7 - k*11 + i*3);
      req_valid = '1;
      chk_ready($sformatf("t2_grant%0d", k), N'(1 << (k % 4)));
      tick();
    end
    req_valid = '0;
    wait_empty("t2_done");

    // Corner products on requester 0, back to back
    for (int k = 0; k < 4; k++) begin
      set_op(0, ca[k], cb[k]);
      req_valid = 4'b0001;
      chk_ready($sformatf("t4_ready%0d", k), 4'b0001);
      tick();
    end
    req_valid = '0;
    wait_empty("t4_done");
    check_eq("t4_last_p", 32'(rsp_p), 32'd0);

    // Drain: 5 ops from pointer 1, then stop
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) set_op(i, 20 + k + i, -9 + k);
      req_valid = '1;
      chk_ready($sformatf("t5_grant%0d", k), N'(1 << ((1 + k) % 4)));
      tick();
    end
    stop = 1'b1;
    for (int k = 0; k < 15; k++) begin
      chk_ready("t5_stopped", 4'b0000);
      tick();
    end
    wait_empty("t5_drain");
    chk_ready("t5_idle", 4'b0000);
    check_eq("t5_busy", 32'(busy), 32'd0);
    tick();
    stop = 1'b0;
    chk_ready("t5_idle_exit", 4'b0000);
    tick();
    chk_ready("t5_resume", 4'b0100);
    tick();

    // Reset mid-flight with 3 ops outstanding
    chk_ready("t6_g3", 4'b1000);
    tick();
    chk_ready("t6_g0", 4'b0001);
    tick();
    req_valid = '0;
    tick();
    check_eq("t6_pre_inflight", 32'(inflight), 32'd3);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_inflight0", 32'(inflight), 32'd0);
    check_eq("t6_busy0", 32'(busy), 32'd0);
    check_eq("t6_mul_en0", 32'(mul_en), 32'd0);
    check_eq("t6_rsp_p0", 32'(rsp_p), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    repeat (15) tick();
    set_op(0, -1, -1);
    req_valid = '1;
    chk_ready("t6_ptr0", 4'b0001);
    tick();
    req_valid = '0;
    wait_empty("t6_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
